// File: rtl/uart_receiver_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_receiver_core : 8O1 UART receive engine. Optional UART_RX_MAJORITY_EN |
// | selects 2-of-3 majority sampling of data, parity and stop bits.            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_receiver_core #(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 19200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       data_strobe,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_busy
);

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int BIT_MAX  = CLK_RATE / BAUD_RATE - 1;
  localparam int HALF_MAX = BIT_MAX / 2;
  localparam int TW       = (clog2(BIT_MAX + 1) < 1) ? 1 : clog2(BIT_MAX + 1);

  localparam logic [TW-1:0] C_BIT_MAX  = TW'(BIT_MAX);
  localparam logic [TW-1:0] C_HALF_MAX = TW'(HALF_MAX);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] STRT   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state, state_next;
  logic          rx_meta, rx_s, rx_d;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic          sample_evt, sample_bit;
  logic          start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Samples at BIT_MAX-1 and BIT_MAX are held; the third is live rx_s one cycle later.
  logic s_early, s_mid, pend;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
      pend    <= 1'b0;
    end else begin
      if (timer == C_BIT_MAX - 1'b1) s_early <= rx_s;
      if (timer == C_BIT_MAX)        s_mid   <= rx_s;
      pend <= (state == DATA || state == PARITY || state == STOP) && (timer == C_BIT_MAX);
    end
  end
  assign sample_evt = pend;
  assign sample_bit = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
  assign sample_evt = (state == DATA || state == PARITY || state == STOP) && (timer == C_BIT_MAX);
  assign sample_bit = rx_s;
`endif

  assign start_ok = (state == STRT) && (timer == C_HALF_MAX) && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_d && !rx_s) state_next = STRT;
      STRT:    if (timer == C_HALF_MAX) state_next = rx_s ? IDLE : DATA;
      DATA:    if (sample_evt && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (sample_evt) state_next = STOP;
      STOP:    if (sample_evt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end

  // Clearing the timer at mid-start aligns every later BIT_MAX hit to mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else begin
      case (state)
        IDLE:    timer <= '0;
        STRT:    timer <= (timer == C_HALF_MAX) ? '0 : timer + 1'b1;
        default: timer <= (timer == C_BIT_MAX)  ? '0 : timer + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 3'd0;
      shift         <= 8'h00;
      par           <= 1'b1;
      data_rx       <= 8'h00;
      data_strobe   <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_strobe <= 1'b0;
      if (start_ok) begin
        bit_cnt <= 3'd0;
        par     <= 1'b1;
      end
      if (sample_evt) begin
        case (state)
          DATA: begin
            shift   <= {sample_bit, shift[7:1]};
            par     <= par ^ sample_bit;
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par <= par ^ sample_bit;
          STOP: begin
            data_rx       <= shift;
            parity_error  <= par;
            framing_error <= ~sample_bit;
            data_strobe   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
